// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared types and default constants for the rectangle draw engine.
//   draw_state_t       : engine FSM state encoding (IDLE / DRAW / DONE)
//   DEFAULT_SCREEN_W   : default visible width in pixels
//   DEFAULT_SCREEN_H   : default visible height in pixels
//   DEFAULT_BG_COLOUR  : default colour written by an erase
// -----------------------------------------------------------------------------
package draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } draw_state_t;

  localparam int DEFAULT_SCREEN_W  = 160;
  localparam int DEFAULT_SCREEN_H  = 120;
  localparam int DEFAULT_BG_COLOUR = 0;

endpackage

// File: rtl/scan_counter_2d.sv
// -----------------------------------------------------------------------------
// scan_counter_2d
// Row-major 2-D offset counter used to walk the pixels of a rectangle.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (offsets to zero)
//   clear    in   synchronous clear (offsets to zero)
//   step     in   advance to the next pixel
//   w, h     in   rectangle width / height (both nonzero while stepping)
//   col_nxt  out  column offset of the pixel after the current one
//   row_nxt  out  row offset of the pixel after the current one
//   last     out  current offsets address the final pixel (w-1, h-1)
// -----------------------------------------------------------------------------
module scan_counter_2d #(
  parameter int SZ_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            step,
  input  logic [SZ_W-1:0] w,
  input  logic [SZ_W-1:0] h,
  output logic [SZ_W-1:0] col_nxt,
  output logic [SZ_W-1:0] row_nxt,
  output logic            last
);

  logic [SZ_W-1:0] col;
  logic [SZ_W-1:0] row;
  logic            col_wrap;

  always_comb begin
    col_wrap = (col == w - SZ_W'(1));
    last     = col_wrap && (row == h - SZ_W'(1));
    col_nxt  = col_wrap ? '0 : col + SZ_W'(1);
    row_nxt  = col_wrap ? row + SZ_W'(1) : row;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule

// File: rtl/rect_draw_engine.sv
// -----------------------------------------------------------------------------
// rect_draw_engine
// Streams the pixels of a filled rectangle, one per clock, in row-major order.
// Optional build macro: RECT_DRAW_CLIP_EN -- suppress plot for pixels outside
// the SCREEN_W x SCREEN_H visible area (those pixels still take their cycle).
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset, priority over start
//   start       in   draw request, sampled only in IDLE
//   x_in, y_in  in   top-left corner
//   w_in, h_in  in   width / height; either zero completes with no pixels
//   colour_in   in   fill colour
//   flash       in   fill with all-ones
//   erase       in   fill with BG_COLOUR (wins over flash)
//   x_out/y_out out  current pixel coordinate (registered)
//   colour_out  out  current pixel colour (registered)
//   plot        out  frame-buffer write strobe (registered)
//   busy        out  from the cycle after acceptance through DONE
//   done        out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module rect_draw_engine
  import draw_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COL_W     = 3,
  parameter int SZ_W      = 5,
  parameter int SCREEN_W  = DEFAULT_SCREEN_W,
  parameter int SCREEN_H  = DEFAULT_SCREEN_H,
  parameter int BG_COLOUR = DEFAULT_BG_COLOUR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [SZ_W-1:0]  w_in,
  input  logic [SZ_W-1:0]  h_in,
  input  logic [COL_W-1:0] colour_in,
  input  logic             flash,
  input  logic             erase,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  draw_state_t      state;
  logic [X_W-1:0]   x_lat;
  logic [Y_W-1:0]   y_lat;
  logic [SZ_W-1:0]  w_lat;
  logic [SZ_W-1:0]  h_lat;

  logic [SZ_W-1:0]  col_nxt;
  logic [SZ_W-1:0]  row_nxt;
  logic             last;

  logic             idle;
  logic             size_ok;
  logic [X_W-1:0]   base_x;
  logic [Y_W-1:0]   base_y;
  logic [SZ_W-1:0]  off_x;
  logic [SZ_W-1:0]  off_y;
  logic [X_W:0]     x_ext;
  logic [Y_W:0]     y_ext;
  logic             pix_plot;
  logic [COL_W-1:0] eff_colour;

  // The counter holds the offsets of the pixel currently on the outputs; it
  // sits at zero outside DRAW so the first pixel is simply the corner.
  scan_counter_2d #(.SZ_W(SZ_W)) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   (state != S_DRAW),
    .step    ((state == S_DRAW) && !last),
    .w       (w_lat),
    .h       (h_lat),
    .col_nxt (col_nxt),
    .row_nxt (row_nxt),
    .last    (last)
  );

  // Coordinate of the pixel to be registered at the next edge: the corner on
  // acceptance (straight from the inputs), otherwise latched corner + offset.
  always_comb begin
    idle    = (state == S_IDLE);
    size_ok = (w_in != '0) && (h_in != '0);
    base_x  = idle ? x_in : x_lat;
    base_y  = idle ? y_in : y_lat;
    off_x   = idle ? '0 : col_nxt;
    off_y   = idle ? '0 : row_nxt;
    x_ext   = {1'b0, base_x} + (X_W+1)'(off_x);
    y_ext   = {1'b0, base_y} + (Y_W+1)'(off_y);
    if (erase)      eff_colour = COL_W'(BG_COLOUR);
    else if (flash) eff_colour = '1;
    else            eff_colour = colour_in;
  end

`ifdef RECT_DRAW_CLIP_EN
  localparam logic [X_W:0] X_LIMIT = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(SCREEN_H);
  assign pix_plot = (x_ext < X_LIMIT) && (y_ext < Y_LIMIT);
`else
  // Unclipped build: carry bits and screen limits only matter for clipping.
  logic unused_clip;
  assign pix_plot    = 1'b1;
  assign unused_clip = ^{x_ext[X_W], y_ext[Y_W], SCREEN_W[0], SCREEN_H[0]};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      x_lat      <= '0;
      y_lat      <= '0;
      w_lat      <= '0;
      h_lat      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (size_ok) begin
              state      <= S_DRAW;
              x_lat      <= x_in;
              y_lat      <= y_in;
              w_lat      <= w_in;
              h_lat      <= h_in;
              colour_out <= eff_colour;
              x_out      <= x_ext[X_W-1:0];
              y_out      <= y_ext[Y_W-1:0];
              plot       <= pix_plot;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (last) begin
            state <= S_DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            x_out <= x_ext[X_W-1:0];
            y_out <= y_ext[Y_W-1:0];
            plot  <= pix_plot;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_draw_engine
// Self-checking bench for rect_draw_engine. Expected pixels are derived from
// the rectangle's definition: pixel k sits at (x + k%w, y + k/w), coordinates
// wrap to the output widths, and (with RECT_DRAW_CLIP_EN) off-screen pixels
// are not plotted.
// -----------------------------------------------------------------------------
module tb_rect_draw_engine;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int BG    = 0;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [4:0] w_in;
  logic [4:0] h_in;
  logic [2:0] colour_in;
  logic       flash;
  logic       erase;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  rect_draw_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .w_in       (w_in),
    .h_in       (h_in),
    .colour_in  (colour_in),
    .flash      (flash),
    .erase      (erase),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input logic [2:0] c, input bit fl, input bit er);
    if (er) return 3'(BG);
    if (fl) return 3'd7;
    return c;
  endfunction

  function automatic bit exp_plot(input int px, input int py);
`ifdef RECT_DRAW_CLIP_EN
    return (px < SCR_W) && (py < SCR_H);
`else
    return 1'b1;
`endif
  endfunction

  // Garbage on every request input while a draw is in flight.
  task automatic scramble(input bit hold);
    start     = hold ? 1'b1 : 1'($urandom);
    x_in      = 8'($urandom);
    y_in      = 7'($urandom);
    w_in      = 5'($urandom);
    h_in      = 5'($urandom);
    colour_in = 3'($urandom);
    flash     = 1'($urandom);
    erase     = 1'($urandom);
  endtask

  // Present a request (start=1) and check every cycle through to idle again.
  // With hold set, start stays high so the next request chains immediately.
  task automatic draw(input int x, input int y, input int w, input int h,
                      input logic [2:0] c, input bit fl, input bit er, input bit hold);
    int n;
    int px;
    int py;
    logic [2:0] ec;
    n  = w * h;
    ec = exp_colour(c, fl, er);
    x_in = 8'(x); y_in = 7'(y); w_in = 5'(w); h_in = 5'(h);
    colour_in = c; flash = fl; erase = er; start = 1'b1;
    @(posedge clock); #1;
    if (n == 0) start = hold; else scramble(hold);
    for (int k = 0; k < n; k++) begin
      px = x + k % w;
      py = y + k / w;
      @(negedge clock);
      check($sformatf("pix%0d.plot", k), plot, exp_plot(px, py));
      check($sformatf("pix%0d.x", k), x_out, px % 256);
      check($sformatf("pix%0d.y", k), y_out, py % 128);
      check($sformatf("pix%0d.colour", k), colour_out, ec);
      check($sformatf("pix%0d.busy", k), busy, 1);
      check($sformatf("pix%0d.done", k), done, 0);
      @(posedge clock); #1;
      if (k < n - 1) scramble(hold); else start = hold;
    end
    @(negedge clock);
    check("done_cycle.done", done, 1);
    check("done_cycle.busy", busy, 1);
    check("done_cycle.plot", plot, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("idle.done", done, 0);
    check("idle.busy", busy, 0);
    check("idle.plot", plot, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1;
    x_in = '0; y_in = '0; w_in = 5'd3; h_in = 5'd3;
    colour_in = '0; flash = 1'b0; erase = 1'b0;

    // Reset holds the engine idle even with start asserted.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.plot", plot, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.x", x_out, 0);
    check("rst.y", y_out, 0);
    check("rst.colour", colour_out, 0);
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);

    // Basic fill.
    draw(10, 20, 3, 2, 3'd5, 0, 0, 0);
    // Degenerate sizes.
    draw(40, 40, 0, 4, 3'd6, 0, 0, 0);
    draw(40, 40, 4, 0, 3'd6, 0, 0, 0);
    // Colour priority.
    draw(1, 2, 2, 2, 3'd3, 1, 1, 0);
    draw(1, 2, 2, 2, 3'd3, 1, 0, 0);
    draw(1, 2, 2, 1, 3'd3, 0, 1, 0);
    // Right / bottom screen edge and 8-bit wrap.
    draw(158, 119, 4, 2, 3'd2, 0, 0, 0);
    draw(254, 126, 3, 3, 3'd1, 0, 0, 0);

    // Reset during the 10th pixel of an 8x8 draw.
    x_in = 8'd5; y_in = 7'd5; w_in = 5'd8; h_in = 5'd8;
    colour_in = 3'd2; flash = 1'b0; erase = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check($sformatf("abort_pix%0d.x", k), x_out, 5 + k % 8);
      check($sformatf("abort_pix%0d.y", k), y_out, 5 + k / 8);
      check($sformatf("abort_pix%0d.plot", k), plot, 1);
      if (k == 9) reset = 1'b1;
      @(posedge clock); #1;
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("abort%0d.plot", k), plot, 0);
      check($sformatf("abort%0d.busy", k), busy, 0);
      check($sformatf("abort%0d.done", k), done, 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    draw(30, 60, 5, 3, 3'd4, 0, 0, 0);

    // Back-to-back with start held high throughout.
    draw(7, 9, 3, 2, 3'd6, 0, 0, 1);
    draw(100, 50, 2, 3, 3'd1, 1, 0, 1);
    draw(20, 30, 1, 1, 3'd3, 0, 0, 0);

    // Randomised requests, half of them near the screen edges.
    for (int r = 0; r < 12; r++) begin
      draw((r % 2 == 1) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255)),
           (r % 2 == 1) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127)),
           int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
           3'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom));
    end
    start = 1'b0;
    @(posedge clock); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rect_draw_engine.md
RECT_DRAW_ENGINE -- requirements
Module: rect_draw_engine

Interface
REQ-001 Parameter X_W, default 8, x coordinate width in bits.
REQ-002 Parameter Y_W, default 7, y coordinate width in bits.
REQ-003 Parameter COL_W, default 3, colour width in bits.
REQ-004 Parameter SZ_W, default 5, width/height field width; max rectangle side 2^SZ_W-1.
REQ-005 Parameter SCREEN_W, default 160, and SCREEN_H, default 120, visible area in pixels.
REQ-006 Parameter BG_COLOUR, default 0, colour used for erase.
REQ-007 clock  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  request to draw; sampled only in IDLE.
REQ-010 x_in / y_in  in  X_W / Y_W  top-left corner.
REQ-011 w_in / h_in  in  SZ_W each  rectangle width / height in pixels.
REQ-012 colour_in  in  COL_W  fill colour.
REQ-013 flash  in  1  force fill colour to all-ones.
REQ-014 erase  in  1  force fill colour to BG_COLOUR.
REQ-015 x_out / y_out  out  X_W / Y_W  current pixel coordinate.
REQ-016 colour_out  out  COL_W  current pixel colour.
REQ-017 plot  out  1  pixel write strobe for the frame buffer.
REQ-018 busy  out  1  high from the cycle after start is accepted until the end of DONE.
REQ-019 done  out  1  single-cycle completion pulse.

Function
REQ-020 FSM states IDLE, DRAW, DONE; the engine SHALL be in exactly one of them.
REQ-021 IDLE with start=1 and w_in,h_in both nonzero SHALL latch x_in, y_in, w_in, h_in, effective colour and enter DRAW.
REQ-022 Effective colour: erase -> BG_COLOUR; else flash -> all-ones; else colour_in. Erase SHALL win over flash. Values are latched at start and SHALL NOT change during the draw.
REQ-023 IDLE with start=1 and w_in=0 or h_in=0 SHALL go directly to DONE with no plot.
REQ-024 DRAW SHALL emit one pixel per cycle in row-major order (x inner, y outer), beginning at (x,y) in the first DRAW cycle: exactly w*h cycles, last pixel (x+w-1, y+h-1).
REQ-025 Coordinates are computed at full width plus one carry bit; x_out/y_out are the truncated values.
REQ-026 plot SHALL be 1 in every DRAW cycle, subject to REQ-034.
REQ-027 After the last pixel, DRAW SHALL enter DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-028 start in DRAW or DONE SHALL be ignored.
REQ-029 start in the IDLE cycle immediately after DONE SHALL be accepted.
REQ-030 Outputs SHALL be registered. Latency from start sample to the first plot is 1 cycle.

Reset
REQ-031 reset SHALL force the following: IDLE, plot=0, busy=0, done=0, x_out=0, y_out=0, colour_out=0, and all counters to 0.
REQ-032 reset during DRAW SHALL abort the draw. plot SHALL be 0 from the next cycle, and no done pulse SHALL follow.
REQ-033 reset SHALL have priority over start.

Configuration
REQ-034 Macro RECT_DRAW_CLIP_EN: when defined, pixels with carry-extended x >= SCREEN_W or y >= SCREEN_H SHALL have plot=0. Such pixels still consume their cycle.
REQ-035 Without RECT_DRAW_CLIP_EN, every DRAW pixel SHALL be plotted, with coordinates wrapping modulo 2^X_W and 2^Y_W.

Structure
REQ-036 Package draw_pkg SHALL hold the state enum type and the default parameter constants (SCREEN_W, SCREEN_H, BG_COLOUR).
REQ-037 Sub-module scan_counter_2d (SZ_W parameter) SHALL generate the column/row offsets plus a last flag. rect_draw_engine holds the FSM, latches and output registers.

Verification
REQ-038 Basic fill: start with (10,20), w=3, h=2, colour=5 -> plot for 6 consecutive cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 5; done pulses 1 cycle after the last pixel.
REQ-039 Degenerate size: w=0, h=4 -> no plot; done pulses 1 cycle later; busy high only during DONE.
REQ-040 Colour priority: flash=1, erase=1, colour=3 -> colour_out=BG_COLOUR. flash=1, erase=0 -> colour_out=7. Changing colour_in mid-draw -> no effect.
REQ-041 Clipping (RECT_DRAW_CLIP_EN): start (158,119), w=4, h=2 -> 8 DRAW cycles; plot=1 only at (158,119),(159,119). Without the macro -> all 8 plotted, x wrapping 255->0 is not reached and y=120 is emitted.
REQ-042 Reset mid-draw: w=8, h=8, reset at 10th pixel -> plot=0 next cycle, busy=0, no done. A new start afterwards is accepted normally.
REQ-043 Back-to-back: start held high continuously -> second draw begins in the IDLE cycle after DONE. start pulses during DRAW -> ignored.
